// File: rtl/lut5_arb_pkg.sv
// Shared constants and FSM state type for the LUT5 evaluation arbiter.
package lut5_arb_pkg;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned TABLE_W = 32;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ID_W    = 2;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } arb_state_e;
endpackage

// File: rtl/lut5_arbiter_if.sv
// Config, request and response handshake bundle for lut5_arbiter.
interface lut5_arbiter_if;
  import lut5_arb_pkg::*;

  logic                     cfg_valid;
  logic [TABLE_W-1:0]       cfg_data;
  logic                     cfg_ready;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*IDX_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_bit;
  logic                     rsp_ready;
  logic [CNT_W-1:0]         eval_count;

  modport master (
    output cfg_valid, cfg_data, req_valid, req_data, rsp_ready,
    input  cfg_ready, req_ready, rsp_valid, rsp_id, rsp_bit, eval_count
  );

  modport slave (
    input  cfg_valid, cfg_data, req_valid, req_data, rsp_ready,
    output cfg_ready, req_ready, rsp_valid, rsp_id, rsp_bit, eval_count
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin grant; search starts one past last_grant.
module rr_arbiter4
  import lut5_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt
);

  // First asserted request at offsets 1..4 from last_grant wins (offset 4 wraps to last_grant).
  always_comb begin
    logic [ID_W-1:0] cand;
    logic            found;
    gnt   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = last_grant + ID_W'(i);
      if (enable && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut5_arbiter.sv
// Arbitrates 4 requesters onto a shared 5-input truth-table lookup with a one-entry result slot.
module lut5_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TABLE_W = 32
) (
  input  logic           CLK,
  input  logic           RESET,
  lut5_arbiter_if.slave  bus
);
  import lut5_arb_pkg::*;

  arb_state_e          state_q;
  logic [TABLE_W-1:0]  table_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic                rsp_bit_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ID_W-1:0]     last_grant_q;

  logic                slot_free;
  logic                cfg_ready;
  logic                cfg_fire;
  logic                grant_en;
  logic                accept;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic [IDX_W-1:0]    sel_idx;

  // Handshake qualifiers; a table load takes priority over a grant in the same cycle.
  always_comb begin
    slot_free = !rsp_valid_q || bus.rsp_ready;
    cfg_ready = !RESET && ((state_q == UNCFG) || slot_free);
    cfg_fire  = bus.cfg_valid && cfg_ready;
    grant_en  = !RESET && (state_q == RUN) && !cfg_fire && slot_free;
  end

  rr_arbiter4 u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .enable     (grant_en),
    .gnt        (gnt)
  );

  // Encode the one-hot grant and select the granted requester's table index.
  always_comb begin
    gnt_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
    end
    accept  = |gnt;
    sel_idx = bus.req_data[gnt_id*IDX_W +: IDX_W];
  end

  // Drive interface outputs from combinational grant and registered slot state.
  always_comb begin
    bus.cfg_ready  = cfg_ready;
    bus.req_ready  = gnt;
    bus.rsp_valid  = rsp_valid_q;
    bus.rsp_id     = rsp_id_q;
    bus.rsp_bit    = rsp_bit_q;
    bus.eval_count = cnt_q;
  end

  // FSM, table register, result slot, acceptance counter and round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= UNCFG;
      table_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_bit_q    <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= '1;
    end else begin
      if (cfg_fire) begin
        table_q <= bus.cfg_data;
        state_q <= RUN;
      end
      if (accept) begin
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= gnt_id;
        rsp_bit_q    <= table_q[sel_idx];
        cnt_q        <= cnt_q + 1'b1;
        last_grant_q <= gnt_id;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lut5_arbiter.md
LUT5_ARBITER -- requirements
Module: lut5_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; fixed at 4 in this revision.
REQ-002 Parameter TABLE_W, default 32: truth-table width (2^5 entries).
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RESET  input  1: reset, synchronous and active-high.
REQ-005 cfg_valid  input  1: new truth table offered.
REQ-006 cfg_data  input  32: truth table; bit k is the output for index k.
REQ-007 cfg_ready  output  1: table accepted when cfg_valid&cfg_ready.
REQ-008 req_valid  input  4: per-requester evaluation request.
REQ-009 req_data  input  20: requester r index at bits [5r+4:5r]; bit 5r is I0.
REQ-010 req_ready  output  4: one-hot grant; request r accepted when req_valid[r]&req_ready[r].
REQ-011 rsp_valid  output  1: result slot holds a valid result.
REQ-012 rsp_id  output  2: requester number of the held result.
REQ-013 rsp_bit  output  1: table[index] of the held result.
REQ-014 rsp_ready  input  1: consumer takes the result when rsp_valid&rsp_ready.
REQ-015 eval_count  output  8: count of accepted requests, wraps 255->0.

Function
REQ-016 FSM states: UNCFG (no valid table) and RUN.
REQ-017 UNCFG: cfg_ready=1, req_ready=0; a cfg handshake loads the table and moves to RUN next cycle.
REQ-018 RUN: cfg_ready=1 only when the result slot is empty, or is being drained this cycle by rsp_ready.
REQ-019 RUN, same cycle as cfg handshake: req_ready=0; the new table applies from the next cycle; the state stays RUN.
REQ-020 Grant condition: in RUN, with no cfg handshake this cycle, and the slot empty or draining this cycle.
REQ-021 When the grant condition holds, exactly one req_ready bit is set, chosen round-robin among asserted req_valid bits.
REQ-022 Round-robin search starts at (last_grant+1) mod 4; last_grant updates only on an accepted request.
REQ-023 req_ready SHALL depend on req_valid combinationally (no combinational path from req_data).
REQ-024 Latency 1 cycle: on acceptance in cycle N, the slot loads rsp_id=r and rsp_bit=table[req_data index] with rsp_valid=1 at edge N+1.
REQ-025 Slot holds rsp_id/rsp_bit stable while rsp_valid=1 and rsp_ready=0.
REQ-026 Simultaneous drain and accept gives back-to-back results, full throughput of 1 per cycle.
REQ-027 Drain with no accept clears rsp_valid at the next edge.
REQ-028 eval_count increments by 1 per accepted request, modulo 256; it is not affected by cfg.
REQ-029 Requests in UNCFG are not accepted and not lost; requesters hold req_valid.

Reset
REQ-030 RESET=1 at an edge gives state=UNCFG, table=0, rsp_valid=0, rsp_id=0, rsp_bit=0, eval_count=0, last_grant=3.
REQ-031 RESET mid-operation discards any held result and the table; outputs reach reset values on the next edge.
REQ-032 While RESET=1, cfg_ready=0 and req_ready=0.

Structure
REQ-033 Shared package lut5_arb_pkg SHALL hold NUM_REQ, IDX_W=5, TABLE_W=32, CNT_W=8 and the state enum {UNCFG,RUN}.
REQ-034 One sub-module, rr_arbiter4, SHALL provide combinational round-robin grant from req, last_grant and enable.
REQ-035 The table lookup SHALL be a 32:1 mux from the table register; no vendor primitives are instantiated.

Verification
REQ-036 Reset, then req_valid=4'b0001 with no cfg -> req_ready=0 and rsp_valid=0 for 10 cycles.
REQ-037 cfg 32'hAAAAAAAA, then req0 index 5'd3 -> rsp_valid one cycle later, rsp_id=0, rsp_bit=1; index 5'd2 gives rsp_bit=0.
REQ-038 All four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0, one per cycle; eval_count=5.
REQ-039 rsp_ready=0 for 3 cycles with the slot full -> req_ready=0 and rsp held stable; releasing rsp_ready gives the next grant that same cycle.
REQ-040 cfg 32'h80000000 and req1 valid in the same cycle with the slot empty -> cfg accepted, no grant; the next cycle req1 index 31 gives rsp_bit=1.
REQ-041 Assert RESET while rsp_valid=1 and eval_count=7 -> next cycle rsp_valid=0, eval_count=0, state UNCFG.
